kws_layer_sched: RTL and testbench

- Inference scheduler for the keyword-spotting CNN.
- Counts MFCC frames from the front-end and decides when an inference runs: after an initial window of frames, then every hop of frames.
- Sequences the layer pipeline (conv1, conv2, maxpool, fc1, fc2, softmax) one layer at a time: start pulse with layer index, wait for done.
- Flags inference requests dropped because the previous inference is still running.

---
 rtl/kws_layer_sched.sv | 175 +++++++++++++++++
 tb/tb_kws_layer_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kws_layer_sched.sv
// Keyword-spotting inference scheduler: frame windowing, layer-by-layer sequencing, overrun flag.
// Build option KWS_SCHED_WDT_EN adds a per-layer watchdog that aborts a stalled inference.
module kws_layer_sched #(
  parameter int NUM_LAYERS     = 6,
  parameter int LAYER_IDX_W    = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   frame_valid,
  input  logic [7:0]             frames_per_infer,
  input  logic [7:0]             hop_frames,
  input  logic                   layer_done,
  input  logic                   clr_overrun,
  output logic                   layer_start,
  output logic [LAYER_IDX_W-1:0] layer_sel,
  output logic                   sched_busy,
  output logic                   result_valid,
  output logic [15:0]            infer_count,
  output logic                   overrun,
  output logic                   sched_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [LAYER_IDX_W-1:0] LAST_SEL = LAYER_IDX_W'(NUM_LAYERS - 1);

  // state is the observable FSM status for checkers bound to this block.
  state_t state;
  state_t state_next;

  logic [7:0] frame_cnt;
  logic       primed;
  logic [7:0] target;
  logic [8:0] cnt_inc;
  logic       trigger;
  logic       last_layer;
  logic       timeout;

  // Frame windowing: a zero window is treated as one frame, and ">=" lets a
  // config shrink below the current count fire on the very next frame.
  always_comb begin
    target = primed ? hop_frames : frames_per_infer;
    if (target == 8'd0) begin
      target = 8'd1;
    end
    cnt_inc = {1'b0, frame_cnt} + 9'd1;
    trigger = enable && frame_valid && (cnt_inc >= {1'b0, target});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 8'd0;
      primed    <= 1'b0;
    end else if (enable && frame_valid) begin
      if (trigger) begin
        frame_cnt <= 8'd0;
        primed    <= 1'b1;
      end else begin
        frame_cnt <= cnt_inc[7:0];
      end
    end
  end

  assign last_layer = (layer_sel == LAST_SEL);

  // Layer handshake: layer_start is a one-cycle request to layer layer_sel;
  // the engine answers with a one-cycle layer_done, honoured only in S_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (trigger) state_next = S_LAUNCH;
      S_LAUNCH: state_next = S_WAIT;
      S_WAIT: begin
        if (layer_done) begin
          state_next = last_layer ? S_DONE : S_LAUNCH;
        end else if (timeout) begin
          state_next = S_IDLE;
        end
      end
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    layer_start  = (state == S_LAUNCH);
    result_valid = (state == S_DONE);
    sched_busy   = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      layer_sel <= '0;
    end else begin
      case (state)
        S_IDLE: if (trigger) layer_sel <= '0;
        S_WAIT: begin
          if (layer_done) begin
            if (!last_layer) begin
              layer_sel <= layer_sel + 1'b1;
            end
          end else if (timeout) begin
            layer_sel <= '0;
          end
        end
        S_DONE:  layer_sel <= '0;
        default: layer_sel <= layer_sel;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      infer_count <= 16'd0;
    end else if (state == S_DONE) begin
      infer_count <= infer_count + 16'd1;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (trigger && (state != S_IDLE)) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef KWS_SCHED_WDT_EN
  localparam logic [15:0] WDT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdt_cnt;
  logic        sched_error_q;

  // Counts cycles spent in S_WAIT; a layer_done on the last allowed cycle wins.
  assign timeout = (state == S_WAIT) && !layer_done && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wdt_cnt       <= 16'd0;
      sched_error_q <= 1'b0;
    end else begin
      sched_error_q <= timeout;
      if (state == S_LAUNCH) begin
        wdt_cnt <= 16'd0;
      end else if (state == S_WAIT) begin
        wdt_cnt <= wdt_cnt + 16'd1;
      end
    end
  end

  assign sched_error = sched_error_q;
`else
  assign timeout     = 1'b0;
  assign sched_error = 1'b0;
`endif

endmodule

// File: tb/tb_kws_layer_sched.sv
// Bench for kws_layer_sched: directed scenarios plus random frames, scored against a
// cycle-schedule model that predicts every layer_start, result_valid and sched_error.
module tb_kws_layer_sched;

  localparam int NL = 6;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_valid = 1'b0;
  logic [7:0]  frames_per_infer = 8'd0;
  logic [7:0]  hop_frames = 8'd0;
  logic        layer_done = 1'b0;
  logic        clr_overrun = 1'b0;
  logic        layer_start;
  logic [2:0]  layer_sel;
  logic        sched_busy;
  logic        result_valid;
  logic [15:0] infer_count;
  logic        overrun;
  logic        sched_error;

  kws_layer_sched #(
    .NUM_LAYERS    (NL),
    .LAYER_IDX_W   (3),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .frame_valid     (frame_valid),
    .frames_per_infer(frames_per_infer),
    .hop_frames      (hop_frames),
    .layer_done      (layer_done),
    .clr_overrun     (clr_overrun),
    .layer_start     (layer_start),
    .layer_sel       (layer_sel),
    .sched_busy      (sched_busy),
    .result_valid    (result_valid),
    .infer_count     (infer_count),
    .overrun         (overrun),
    .sched_error     (sched_error)
  );

  // ---------------- clock / cycle index ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] start_q[$];
  logic [31:0] sel_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] err_q[$];
  int   m_cnt = 0;
  int   m_primed = 0;
  int   m_busy_start = -1;
  int   m_busy_end = -1;
  int   m_infers = 0;
  logic m_ov = 1'b0;
  int   done_delay = 1;
  int   withhold_sel = -1;
  bit   mon_on = 1'b0;
  logic en_req = 1'b0;
  logic [7:0] fpi_req = 8'd0;
  logic [7:0] hop_req = 8'd0;

  // An accepted trigger at cycle t: layer k starts at t+1+k*(d+1), result after the last done.
  task automatic plan(input int t);
    int last;
    last = (withhold_sel >= 0) ? withhold_sel : NL - 1;
    for (int k = 0; k <= last; k++) begin
      start_q.push_back(t + 1 + k * (done_delay + 1));
      sel_q.push_back(k);
    end
    m_busy_start = t;
    if (withhold_sel >= 0) begin
      m_busy_end = t + 1 + withhold_sel * (done_delay + 1) + TO;
      err_q.push_back(m_busy_end + 1);
    end else begin
      m_busy_end = t + 1 + NL * (done_delay + 1);
      exp_q.push_back(m_busy_end);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit fv, input bit clr, input bit r);
    bit trig;
    int tgt;
    @(posedge clk);
    #1;
    frame_valid = fv;
    clr_overrun = clr;
    rst = r;
    enable = en_req;
    frames_per_infer = fpi_req;
    hop_frames = hop_req;
    trig = 1'b0;
    if (r) begin
      m_cnt = 0;
      m_primed = 0;
      m_ov = 1'b0;
      if (m_busy_end > cyc) m_busy_end = cyc;
      while (start_q.size() > 0 && start_q[$] > cyc) begin
        void'(start_q.pop_back());
        void'(sel_q.pop_back());
      end
      while (exp_q.size() > 0 && exp_q[$] > cyc) void'(exp_q.pop_back());
      while (err_q.size() > 0 && err_q[$] > cyc) void'(err_q.pop_back());
    end else if (fv && en_req) begin
      tgt = m_primed ? int'(hop_req) : int'(fpi_req);
      if (tgt == 0) tgt = 1;
      if (m_cnt + 1 >= tgt) begin
        trig = 1'b1;
        m_cnt = 0;
        m_primed = 1;
      end else begin
        m_cnt++;
      end
    end
    if (trig && cyc <= m_busy_end) m_ov = 1'b1;
    else if (!r && clr) m_ov = 1'b0;
    if (trig && cyc > m_busy_end) plan(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- layer engine + per-cycle monitor ----------------
  initial begin : engine_and_monitor
    int pend;
    bit exp_start;
    bit exp_res;
    bit exp_err;
    pend = 0;
    forever begin
      @(negedge clk);
      layer_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) layer_done = 1'b1;
      end
      if (layer_start && !rst && int'(layer_sel) != withhold_sel) pend = done_delay;
      if (rst) begin
        pend = 0;
        layer_done = 1'b0;
      end
      if (mon_on) begin
        exp_start = (start_q.size() > 0) && (start_q[0] == cyc);
        check("layer_start", layer_start, exp_start);
        if (exp_start) begin
          check("layer_sel", layer_sel, sel_q[0]);
          void'(start_q.pop_front());
          void'(sel_q.pop_front());
        end
        exp_res = (exp_q.size() > 0) && (exp_q[0] == cyc);
        check("result_valid", result_valid, exp_res);
        check("infer_count", infer_count, m_infers);
        if (exp_res) begin
          void'(exp_q.pop_front());
          m_infers = (m_infers + 1) % 65536;
        end
        exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
        check("sched_error", sched_error, exp_err);
        if (exp_err) void'(err_q.pop_front());
        check("sched_busy", sched_busy, (cyc > m_busy_start) && (cyc <= m_busy_end));
        if (rst) m_infers = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int tcyc;
    int rcyc;
    int ecyc;
    bit found;

    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    mon_on = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("rst_layer_start", layer_start, 1'b0);
    check("rst_layer_sel", layer_sel, 3'd0);
    check("rst_busy", sched_busy, 1'b0);
    check("rst_result", result_valid, 1'b0);
    check("rst_infer_count", infer_count, 16'd0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_sched_error", sched_error, 1'b0);

    // Priming window 4, hop 2, engine answers 3 cycles after each start.
    en_req = 1'b1; fpi_req = 8'd4; hop_req = 8'd2; done_delay = 3;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(13);
    end
    idle(30);
    check("prime_infers", infer_count, 16'd5);
    check("prime_overrun", overrun, 1'b0);

    // Fast engine: result 2*NL+1 cycles after the trigger.
    hop_req = 8'd1; done_delay = 1;
    step(1'b1, 1'b0, 1'b0);
    tcyc = cyc;
    rcyc = 0;
    for (int i = 0; i < 30 && rcyc == 0; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (result_valid) rcyc = cyc;
    end
    check("fast_latency", rcyc - tcyc, 2 * NL + 1);
    idle(3);

    // Overrun: slow engine, frames every 5 cycles.
    done_delay = 20;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(4);
    end
    idle(1);
    check("overrun_set", overrun, 1'b1);
    idle(130);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    check("overrun_clr", overrun, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b1, 1'b0);
    idle(1);
    check("overrun_set_wins", overrun, 1'b1);
    idle(130);
    step(1'b0, 1'b1, 1'b0);
    idle(1);
    check("overrun_model", overrun, m_ov);

    // Zero config: every frame triggers.
    fpi_req = 8'd0; hop_req = 8'd0; done_delay = 1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(15);
    end
    check("zero_cfg_infers", infer_count, 16'd12);

    // Enable low freezes counting but not an in-flight inference.
    hop_req = 8'd3;
    step(1'b1, 1'b0, 1'b0); idle(2);
    step(1'b1, 1'b0, 1'b0); idle(2);
    en_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0); idle(2);
    end
    en_req = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    en_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0); idle(2);
    end
    idle(10);
    en_req = 1'b1;
    check("enable_infers", infer_count, 16'd13);

    // Reset while layer 3 is in WAIT.
    hop_req = 8'd1; done_delay = 3;
    step(1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 1'b0, 1'b0);
      found = layer_start && (layer_sel == 3'd3);
    end
    check("wait_layer3", found, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("mid_rst_start", layer_start, 1'b0);
    check("mid_rst_sel", layer_sel, 3'd0);
    check("mid_rst_busy", sched_busy, 1'b0);
    check("mid_rst_infer_count", infer_count, 16'd0);
    check("mid_rst_overrun", overrun, 1'b0);
    fpi_req = 8'd3; hop_req = 8'd2; done_delay = 1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      idle(14);
    end
    check("reprime_infers", infer_count, 16'd1);

    // Randomized frames, config, enable, clears and engine speed.
    for (int it = 0; it < 80; it++) begin
      if (cyc > m_busy_end) done_delay = $urandom_range(1, 4);
      fpi_req = 8'($urandom_range(0, 4));
      hop_req = 8'($urandom_range(0, 4));
      en_req = ($urandom_range(0, 7) != 0);
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'b0);
      idle($urandom_range(0, 6));
    end
    en_req = 1'b1;
    idle(60);
    check("random_overrun", overrun, m_ov);
    check("random_infer_count", infer_count, m_infers);

`ifdef KWS_SCHED_WDT_EN
    // Watchdog: layer 2 never answers.
    step(1'b0, 1'b1, 1'b0);
    hop_req = 8'd1; done_delay = 2; withhold_sel = 2;
    step(1'b1, 1'b0, 1'b0);
    tcyc = cyc;
    withhold_sel = -1;
    ecyc = 0;
    for (int i = 0; i < 60 && ecyc == 0; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (sched_error) ecyc = cyc;
    end
    check("wdt_delay", ecyc - (tcyc + 1 + 2 * 3 + 1), TO);
    check("wdt_idle", sched_busy, 1'b0);
    idle(5);
    // Engine answers on the last allowed WAIT cycle of every layer.
    done_delay = TO;
    step(1'b1, 1'b0, 1'b0);
    idle(120);
`endif

    idle(5);
    check("queues_drained", start_q.size() + exp_q.size() + err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a loop above never terminates.
  initial begin : time_guard
    #2000000;
    $display("FAIL time_guard: got=timeout expected=finish");
    $fatal(1, "time limit reached");
  end

endmodule
